// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and ROM fetch initiator feeding decode through a small queue.
// Optional IFU_PERF_EN adds saturating fetch/stall counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`INST_WIDTH{1'b0}}
`endif

module ifu_fetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_rom_rd_en,
  output logic [`ADDR_WIDTH-1:0] o_rom_rd_addr,
  input  logic [`INST_WIDTH-1:0] i_rom_rd_data,
  input  logic                   i_jmp_en,
  input  logic [`ADDR_WIDTH-1:0] i_jmp_addr,
  output logic                   o_ifu_valid,
  input  logic                   i_idu_ready,
  output logic [`INST_WIDTH-1:0] o_ifu_inst,
  output logic [`ADDR_WIDTH-1:0] o_ifu_pc,
  output logic                   o_ifu_misalign
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]            o_perf_fetch_cnt,
  output logic [31:0]            o_perf_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic [`ADDR_WIDTH-1:0] r_pc;
  logic [`ADDR_WIDTH-1:0] r_q_pc   [FIFO_DEPTH];
  logic [`INST_WIDTH-1:0] r_q_inst [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_cnt;
  logic                   r_mis;

  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & i_idu_ready;
  assign w_full  = (r_cnt == DEPTH);

  // A pop frees a slot in the same cycle, so a full queue can still fetch
  assign o_rom_rd_en   = i_rst_n & ~i_jmp_en & (~w_full | w_pop);
  assign o_rom_rd_addr = r_pc;
  assign w_push        = o_rom_rd_en;

  assign o_ifu_valid    = w_valid;
  assign o_ifu_inst     = w_valid ? r_q_inst[r_rptr] : `DATA_ZERO;
  assign o_ifu_pc       = w_valid ? r_q_pc[r_rptr] : `ADDR_INIT;
  assign o_ifu_misalign = r_mis;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc   <= `ADDR_INIT;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_mis  <= 1'b0;
    end else begin
      r_mis <= i_jmp_en & (i_jmp_addr[1:0] != 2'b00);
      if (i_jmp_en) begin
        r_pc   <= {i_jmp_addr[`ADDR_WIDTH-1:2], 2'b00};
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= r_pc + `ADDR_WIDTH'(4);
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        if (w_push & ~w_pop) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (w_pop & ~w_push) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_pc[i]   <= `ADDR_INIT;
        r_q_inst[i] <= `DATA_ZERO;
      end
    end else if (w_push) begin
      r_q_pc[r_wptr]   <= r_pc;
      r_q_inst[r_wptr] <= i_rom_rd_data;
    end
  end

`ifdef IFU_PERF_EN
  logic w_stall;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  assign w_stall = w_full & ~w_pop & ~i_jmp_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_perf_fetch_cnt = r_fetch_cnt;
  assign o_perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed steps against a PC/queue scoreboard model.
// Build with IFU_PERF_EN to also check the performance counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_ifu_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] INIT = 32'h8000_0000;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_rom_rd_en;
  logic [31:0] o_rom_rd_addr;
  logic [31:0] i_rom_rd_data;
  logic        i_jmp_en;
  logic [31:0] i_jmp_addr;
  logic        o_ifu_valid;
  logic        i_idu_ready;
  logic [31:0] o_ifu_inst;
  logic [31:0] o_ifu_pc;
  logic        o_ifu_misalign;
`ifdef IFU_PERF_EN
  logic [31:0] o_perf_fetch_cnt;
  logic [31:0] o_perf_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  ifu_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_rom_rd_en   (o_rom_rd_en),
    .o_rom_rd_addr (o_rom_rd_addr),
    .i_rom_rd_data (i_rom_rd_data),
    .i_jmp_en      (i_jmp_en),
    .i_jmp_addr    (i_jmp_addr),
    .o_ifu_valid   (o_ifu_valid),
    .i_idu_ready   (i_idu_ready),
    .o_ifu_inst    (o_ifu_inst),
    .o_ifu_pc      (o_ifu_pc),
    .o_ifu_misalign(o_ifu_misalign)
`ifdef IFU_PERF_EN
    ,
    .o_perf_fetch_cnt(o_perf_fetch_cnt),
    .o_perf_stall_cnt(o_perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  assign i_rom_rd_data = rom_f(o_rom_rd_addr);

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = INIT;
    m_mis   = 1'b0;
    m_fetch = '0;
    m_stall = '0;
  endtask

  task automatic cyc(input logic jmp, input logic [31:0] ja,
                     input logic rdy);
    logic e_pop;
    logic e_en;
    logic [63:0] h;
    i_jmp_en    = jmp;
    i_jmp_addr  = ja;
    i_idu_ready = rdy;
    #1;
    e_pop = (q.size() != 0) && rdy;
    e_en  = !jmp && ((q.size() < DEPTH) || e_pop);
    chk("rd_en", 64'(o_rom_rd_en), 64'(e_en));
    chk("rd_addr", 64'(o_rom_rd_addr), 64'(m_pc));
    chk("valid", 64'(o_ifu_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      chk("head_pc", 64'(o_ifu_pc), 64'(h[63:32]));
      chk("head_inst", 64'(o_ifu_inst), 64'(h[31:0]));
    end else begin
      chk("idle_pc", 64'(o_ifu_pc), 64'(INIT));
      chk("idle_inst", 64'(o_ifu_inst), 64'd0);
    end
    chk("misalign", 64'(o_ifu_misalign), 64'(m_mis));
`ifdef IFU_PERF_EN
    chk("fetch_cnt", 64'(o_perf_fetch_cnt), 64'(m_fetch));
    chk("stall_cnt", 64'(o_perf_stall_cnt), 64'(m_stall));
`endif
    if ((q.size() == DEPTH) && !e_pop && !jmp) m_stall++;
    @(posedge i_clk);
    if (jmp) begin
      q.delete();
      m_pc  = {ja[31:2], 2'b00};
      m_mis = (ja[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (e_pop) void'(q.pop_front());
      if (e_en) begin
        q.push_back({m_pc, rom_f(m_pc)});
        m_pc = m_pc + 32'd4;
        m_fetch++;
      end
    end
    #1;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_jmp_en    = 1'b0;
    i_jmp_addr  = '0;
    i_idu_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(o_ifu_valid), 64'd0);
    chk("rst_pc", 64'(o_ifu_pc), 64'(INIT));
    chk("rst_inst", 64'(o_ifu_inst), 64'd0);
    chk("rst_mis", 64'(o_ifu_misalign), 64'd0);
    chk("rst_rd_en", 64'(o_rom_rd_en), 64'd0);
    chk("rst_addr", 64'(o_rom_rd_addr), 64'(INIT));
    i_rst_n = 1'b1;

    // streaming fetch
    repeat (3) cyc(1'b0, '0, 1'b1);
    chk("t1_pc", 64'(o_ifu_pc), 64'h8000_0008);
    chk("t1_addr", 64'(o_rom_rd_addr), 64'h8000_000C);

    // back-pressure until full
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("t2_hold_en", 64'(o_rom_rd_en), 64'd0);
    chk("t2_hold_addr", 64'(o_rom_rd_addr), 64'h8000_0010);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // redirect while full
    cyc(1'b1, 32'h8000_0100, 1'b0);
    chk("t3_valid", 64'(o_ifu_valid), 64'd0);
    chk("t3_addr", 64'(o_rom_rd_addr), 64'h8000_0100);
    cyc(1'b0, '0, 1'b1);
    chk("t3_head", 64'(o_ifu_pc), 64'h8000_0100);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // misaligned redirect
    cyc(1'b1, 32'h8000_0102, 1'b1);
    chk("t4_mis", 64'(o_ifu_misalign), 64'd1);
    chk("t4_addr", 64'(o_rom_rd_addr), 64'h8000_0100);
    cyc(1'b0, '0, 1'b1);
    chk("t4_mis_clr", 64'(o_ifu_misalign), 64'd0);
    cyc(1'b0, '0, 1'b1);

    // PC wrap
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("wrap_addr", 64'(o_rom_rd_addr), 64'd0);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // async reset with entries queued
    repeat (3) cyc(1'b0, '0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(o_ifu_valid), 64'd0);
    chk("t5_addr", 64'(o_rom_rd_addr), 64'(INIT));
    chk("t5_pc", 64'(o_ifu_pc), 64'(INIT));
    chk("t5_rd_en", 64'(o_rom_rd_en), 64'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // 10 fetches then 3 full stalls
    repeat (9) cyc(1'b0, '0, 1'b1);
    repeat (4) cyc(1'b0, '0, 1'b0);
`ifdef IFU_PERF_EN
    chk("t6_fetch", 64'(o_perf_fetch_cnt), 64'd10);
    chk("t6_stall", 64'(o_perf_stall_cnt), 64'd3);
    cyc(1'b1, 32'h8000_0200, 1'b0);
    chk("t6_keep", 64'(o_perf_fetch_cnt), 64'd10);
`endif
    repeat (3) cyc(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
